// File: rtl/i2c_master_transfer_ctrl.sv
// Byte-level I2C master sequencer: one request becomes START, address+R/W, ACK slots,
// 1..N data bytes and STOP on open-drain SCL/SDA, with quarter-period timing and SCL stretching.
module i2c_master_transfer_ctrl #(
    parameter int unsigned CLK_DIV             = 4,
    parameter int unsigned SLAVE_ADDRESS_WIDTH = 7,
    parameter int unsigned DATA_WIDTH          = 32
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [SLAVE_ADDRESS_WIDTH-1:0] req_addr,
    input  logic                           req_read_write,
    input  logic                           req_msb_first,
    input  logic [2:0]                     req_no_of_bytes,
    input  logic [DATA_WIDTH-1:0]          req_wdata,
    output logic                           busy,
    output logic                           done,
    output logic                           nack_error,
    output logic [DATA_WIDTH-1:0]          rdata,
    input  logic                           scl_i,
    input  logic                           sda_i,
    output logic                           scl_oe,
    output logic                           sda_oe
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BYTE_MAX = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (BYTE_MAX > 1) ? $clog2(BYTE_MAX) : 1;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } read_write_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_STOP
    } state_e;

    state_e                 state;
    logic [DIV_W-1:0]       div_cnt;
    logic [1:0]             q;
    logic [2:0]             bit_cnt;
    logic [IDX_W-1:0]       byte_idx;
    logic [IDX_W-1:0]       last_idx;
    read_write_e            rw_q;
    logic                   msb_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [7:0]             tx;
    logic [7:0]             rx;
    logic                   ack_bit;

    logic                   stretched;
    logic                   tick;
    logic [IDX_W-1:0]       req_last;
    logic [IDX_W-1:0]       wsel_idx;
    logic [7:0]             wr_byte;
    logic [7:0]             wr_tx;
    logic [7:0]             rx_byte;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // A released SCL that still reads low is a slave stretching the clock: freeze the divider.
    assign stretched = !scl_oe && !scl_i;
    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1)) && !stretched;

    always_comb begin
        req_last = '0;
        if (req_no_of_bytes != 3'd0 && 32'(req_no_of_bytes) <= BYTE_MAX) begin
            req_last = IDX_W'(req_no_of_bytes - 3'd1);
        end
    end

    // Next write byte to load: byte 0 after the address ACK, otherwise the following byte.
    assign wsel_idx = (state == S_ADDR_ACK) ? '0 : byte_idx + IDX_W'(1);
    assign wr_byte  = wdata_q[{wsel_idx, 3'b000} +: 8];
    assign wr_tx    = msb_q ? wr_byte : rev8(wr_byte);
    assign rx_byte  = msb_q ? rx : rev8(rx);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            q          <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            last_idx   <= '0;
            rw_q       <= WRITE;
            msb_q      <= 1'b1;
            wdata_q    <= '0;
            tx         <= '0;
            rx         <= '0;
            ack_bit    <= 1'b1;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack_error <= 1'b0;
            rdata      <= '0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && !stretched) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state      <= S_START;
                        div_cnt    <= '0;
                        q          <= '0;
                        byte_idx   <= '0;
                        last_idx   <= req_last;
                        rw_q       <= read_write_e'(req_read_write);
                        msb_q      <= req_msb_first;
                        wdata_q    <= req_wdata;
                        tx         <= 8'({req_addr, req_read_write});
                        busy       <= 1'b1;
                        req_ready  <= 1'b0;
                        nack_error <= 1'b0;
                        rdata      <= '0;
                        scl_oe     <= 1'b0;
                        sda_oe     <= 1'b0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        if (q == 2'd0) begin
                            sda_oe <= 1'b1;
                        end else if (q == 2'd2) begin
                            state   <= S_ADDR;
                            q       <= '0;
                            bit_cnt <= '0;
                            scl_oe  <= 1'b1;
                            sda_oe  <= ~tx[7];
                        end
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        if (q == 2'd0) begin
                            scl_oe <= 1'b0;
                        end else if (q == 2'd1) begin
                            sda_oe <= 1'b0;
                        end else if (q == 2'd2) begin
                            state     <= S_IDLE;
                            q         <= '0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end
                    end
                end

                // Bit slots: P0-P1 SCL low, P2-P3 released; SDA only moves on entry to P0.
                default: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        if (q == 2'd1) begin
                            scl_oe <= 1'b0;
                        end
                        if (q == 2'd2) begin
                            rx      <= {rx[6:0], sda_i};
                            ack_bit <= sda_i;
                        end
                        if (q == 2'd3) begin
                            q      <= '0;
                            scl_oe <= 1'b1;
                            case (state)
                                S_ADDR: begin
                                    if (bit_cnt == 3'd7) begin
                                        state  <= S_ADDR_ACK;
                                        sda_oe <= 1'b0;
                                    end else begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        tx      <= tx << 1;
                                        sda_oe  <= ~tx[6];
                                    end
                                end
                                S_ADDR_ACK: begin
                                    bit_cnt <= '0;
                                    if (ack_bit) begin
                                        nack_error <= 1'b1;
                                        state      <= S_STOP;
                                        sda_oe     <= 1'b1;
                                    end else if (rw_q == READ) begin
                                        state  <= S_RD_BYTE;
                                        sda_oe <= 1'b0;
                                    end else begin
                                        state  <= S_WR_BYTE;
                                        tx     <= wr_tx;
                                        sda_oe <= ~wr_tx[7];
                                    end
                                end
                                S_WR_BYTE: begin
                                    if (bit_cnt == 3'd7) begin
                                        state  <= S_WR_ACK;
                                        sda_oe <= 1'b0;
                                    end else begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        tx      <= tx << 1;
                                        sda_oe  <= ~tx[6];
                                    end
                                end
                                S_WR_ACK: begin
                                    bit_cnt <= '0;
                                    if (ack_bit) begin
                                        nack_error <= 1'b1;
                                        state      <= S_STOP;
                                        sda_oe     <= 1'b1;
                                    end else if (byte_idx == last_idx) begin
                                        state  <= S_STOP;
                                        sda_oe <= 1'b1;
                                    end else begin
                                        byte_idx <= byte_idx + IDX_W'(1);
                                        state    <= S_WR_BYTE;
                                        tx       <= wr_tx;
                                        sda_oe   <= ~wr_tx[7];
                                    end
                                end
                                S_RD_BYTE: begin
                                    if (bit_cnt == 3'd7) begin
                                        rdata[{byte_idx, 3'b000} +: 8] <= rx_byte;
                                        state  <= S_RD_ACK;
                                        sda_oe <= (byte_idx != last_idx);
                                    end else begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        sda_oe  <= 1'b0;
                                    end
                                end
                                S_RD_ACK: begin
                                    bit_cnt <= '0;
                                    if (byte_idx == last_idx) begin
                                        state  <= S_STOP;
                                        sda_oe <= 1'b1;
                                    end else begin
                                        byte_idx <= byte_idx + IDX_W'(1);
                                        state    <= S_RD_BYTE;
                                        sda_oe   <= 1'b0;
                                    end
                                end
                                default: begin
                                    state  <= S_STOP;
                                    sda_oe <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_transfer_ctrl.sv
// Bench for i2c_master_transfer_ctrl: table of transfers against a bus-level slave model,
// wire bytes and master ACKs checked through a scoreboard, plus reset and stretch sequences.
`timescale 1ns/1ps
module tb_i2c_master_transfer_ctrl;

    localparam int unsigned CLK_DIV = 4;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_addr = '0;
    logic        req_read_write = 1'b0;
    logic        req_msb_first = 1'b1;
    logic [2:0]  req_no_of_bytes = '0;
    logic [31:0] req_wdata = '0;
    logic        busy, done, nack_error;
    logic [31:0] rdata;
    logic        scl_i, sda_i, scl_oe, sda_oe;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic        msb;
        logic [2:0]  nb;
        logic [31:0] wdata;
        int          present;   // 0 none, 1 acks everything, 2 acks address only
        logic [31:0] slave_rd;  // wire bytes the slave returns, byte k at [8k+7:8k]
        int          stretch;
        logic [31:0] exp_rdata;
        logic        exp_nack;
        int          exp_quarters;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q[$];
    logic       exp_ack_q[$];

    // slave / bus model state
    logic        stretch = 1'b0;
    int          stretch_left = 0;
    int          stretch_req = 0;
    logic        slave_sda = 1'b0;
    int          present = 1;
    logic [31:0] slave_rd = '0;
    logic        scl_prev = 1'b1;
    logic        sda_prev = 1'b1;
    int          cnt = 0;
    int          nbyte = 0;
    logic        rd_mode = 1'b0;
    logic [7:0]  shreg = '0;
    logic        ackbit = 1'b1;
    int          starts = 0;
    int          stops = 0;

    assign scl_i = !scl_oe && !stretch;
    assign sda_i = !sda_oe && !slave_sda;

    i2c_master_transfer_ctrl #(
        .CLK_DIV             (CLK_DIV),
        .SLAVE_ADDRESS_WIDTH (7),
        .DATA_WIDTH          (32)
    ) dut (
        .pclk            (pclk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_read_write  (req_read_write),
        .req_msb_first   (req_msb_first),
        .req_no_of_bytes (req_no_of_bytes),
        .req_wdata       (req_wdata),
        .busy            (busy),
        .done            (done),
        .nack_error      (nack_error),
        .rdata           (rdata),
        .scl_i           (scl_i),
        .sda_i           (sda_i),
        .scl_oe          (scl_oe),
        .sda_oe          (sda_oe)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] wire_byte(input logic [7:0] b, input logic msb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return msb ? b : r;
    endfunction

    // Bus-level slave: decodes START/STOP/bits from the lines, ACKs, returns read data, stretches SCL.
    always @(negedge pclk) begin : slave_model
        logic scl_now, sda_now;
        if (rst) begin
            stretch   = 1'b0;
            slave_sda = 1'b0;
            scl_prev  = 1'b1;
            sda_prev  = 1'b1;
            cnt       = 0;
            nbyte     = 0;
            rd_mode   = 1'b0;
        end else begin
            if (stretch && !scl_oe) begin
                if (stretch_left == 0) stretch = 1'b0;
                else stretch_left--;
            end
            scl_now = !scl_oe && !stretch;
            sda_now = !sda_oe && !slave_sda;
            if (scl_prev && scl_now && sda_prev && !sda_now) begin
                starts++;
                cnt = 0; nbyte = 0; rd_mode = 1'b0; slave_sda = 1'b0;
            end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
                stops++;
                slave_sda = 1'b0;
            end else if (!scl_prev && scl_now) begin
                if (cnt < 8) begin
                    shreg = {shreg[6:0], sda_now};
                end else begin
                    ackbit = sda_now;
                    if (rd_mode && nbyte > 0) begin
                        if (exp_ack_q.size() == 0) begin
                            n_total++;
                            $display("FAIL master_ack: got %0b with no ACK slot expected", sda_now);
                        end else begin
                            chk("master_ack", 32'(sda_now), 32'(exp_ack_q.pop_front()));
                        end
                    end
                end
                cnt++;
                if (cnt == 9) begin
                    cnt = 0;
                    nbyte++;
                end
            end else if (scl_prev && !scl_now) begin
                if (cnt == 8) begin
                    if (nbyte == 0 || !rd_mode) begin
                        if (exp_q.size() == 0) begin
                            n_total++;
                            $display("FAIL bus_byte: got 0x%0h with no byte expected", shreg);
                        end else begin
                            chk("bus_byte", 32'(shreg), 32'(exp_q.pop_front()));
                        end
                    end
                    if (nbyte == 0) begin
                        rd_mode   = shreg[0];
                        slave_sda = (present > 0);
                    end else if (!rd_mode) begin
                        slave_sda = (present == 1);
                    end else begin
                        slave_sda = 1'b0;
                    end
                end else if (cnt == 0 && nbyte > 0) begin
                    if (rd_mode && !ackbit) slave_sda = !slave_rd[8*(nbyte-1)+7];
                    else slave_sda = 1'b0;
                    if (!rd_mode && nbyte == 1 && stretch_req > 0) begin
                        stretch      = 1'b1;
                        stretch_left = stretch_req;
                    end
                end else if (cnt > 0 && rd_mode && nbyte > 0) begin
                    slave_sda = !slave_rd[8*(nbyte-1)+7-cnt];
                end
            end
            scl_prev = scl_now;
            sda_prev = !sda_oe && !slave_sda;
        end
    end

    task automatic run_vec(input vec_t v);
        int cyc, s0, p0, nb;
        nb = (v.nb == 3'd0 || v.nb > 3'd4) ? 1 : int'(v.nb);
        exp_q.push_back({v.addr, v.rw});
        if (!v.rw) begin
            for (int k = 0; k < nb; k++) begin
                if (v.present == 1 || (v.present == 2 && k == 0))
                    exp_q.push_back(wire_byte(v.wdata[8*k +: 8], v.msb));
            end
        end else if (v.present > 0) begin
            for (int k = 0; k < nb; k++) exp_ack_q.push_back(k == nb - 1);
        end
        present     = v.present;
        slave_rd    = v.slave_rd;
        stretch_req = v.stretch;
        s0 = starts;
        p0 = stops;

        req_addr        = v.addr;
        req_read_write  = v.rw;
        req_msb_first   = v.msb;
        req_no_of_bytes = v.nb;
        req_wdata       = v.wdata;
        req_valid       = 1'b1;
        @(negedge pclk);
        req_valid = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ready", 32'(req_ready), 32'd0);

        cyc = 0;
        while (!done && cyc < 20000) begin
            cyc++;
            // a request presented mid-transfer must be ignored
            if (cyc == 40) begin
                req_valid = 1'b1;
                req_addr  = ~v.addr;
            end
            if (cyc == 50) req_valid = 1'b0;
            @(negedge pclk);
        end
        chk("done_latency", 32'(cyc), 32'(v.exp_quarters * CLK_DIV + v.stretch));
        chk("nack_error", 32'(nack_error), 32'(v.exp_nack));
        chk("rdata", rdata, v.exp_rdata);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ready", 32'(req_ready), 32'd1);
        chk("start_count", 32'(starts - s0), 32'd1);
        chk("stop_count", 32'(stops - p0), 32'd1);
        chk("bytes_left", 32'(exp_q.size()), 32'd0);
        chk("acks_left", 32'(exp_ack_q.size()), 32'd0);
        @(negedge pclk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("nack_held", 32'(nack_error), 32'(v.exp_nack));
        chk("idle_bus", 32'({scl_oe, sda_oe}), 32'd0);
        exp_q.delete();
        exp_ack_q.delete();
        stretch_req = 0;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{7'h68, 1'b0, 1'b1, 3'd2, 32'h0000_A55A, 1, 32'h0, 0,  32'h0,         1'b0, 114};
        vecs[1]  = '{7'h6C, 1'b1, 1'b1, 3'd3, 32'h0,         1, 32'h0033_2211, 0, 32'h0033_2211, 1'b0, 150};
        vecs[2]  = '{7'h7C, 1'b0, 1'b1, 3'd1, 32'h12,        0, 32'h0, 0,  32'h0,         1'b1, 42};
        vecs[3]  = '{7'h55, 1'b0, 1'b0, 3'd1, 32'h01,        1, 32'h0, 0,  32'h0,         1'b0, 78};
        vecs[4]  = '{7'h68, 1'b0, 1'b1, 3'd2, 32'h0000_A55A, 1, 32'h0, 20, 32'h0,         1'b0, 114};
        vecs[5]  = '{7'h21, 1'b1, 1'b0, 3'd2, 32'h0,         1, 32'h0000_0380, 0, 32'h0000_C001, 1'b0, 114};
        vecs[6]  = '{7'h3A, 1'b0, 1'b1, 3'd0, 32'hDEAD_BEEF, 1, 32'h0, 0,  32'h0,         1'b0, 78};
        vecs[7]  = '{7'h3A, 1'b0, 1'b1, 3'd7, 32'hDEAD_BEEF, 1, 32'h0, 0,  32'h0,         1'b0, 78};
        vecs[8]  = '{7'h12, 1'b0, 1'b1, 3'd4, 32'h0403_0201, 1, 32'h0, 0,  32'h0,         1'b0, 186};
        vecs[9]  = '{7'h40, 1'b1, 1'b1, 3'd2, 32'h0,         0, 32'hFFFF_FFFF, 0, 32'h0,   1'b1, 42};
        vecs[10] = '{7'h33, 1'b0, 1'b1, 3'd3, 32'h00C0_FFEE, 2, 32'h0, 0,  32'h0,         1'b1, 78};

        repeat (3) @(negedge pclk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_nack", 32'(nack_error), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        rst = 1'b0;
        @(negedge pclk);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
            repeat (3) @(negedge pclk);
        end

        // reset in the middle of the first data byte, then a normal transfer
        exp_q.push_back(8'hD0);
        present         = 1;
        req_addr        = 7'h68;
        req_read_write  = 1'b0;
        req_msb_first   = 1'b1;
        req_no_of_bytes = 3'd2;
        req_wdata       = 32'h0000_A55A;
        req_valid       = 1'b1;
        @(negedge pclk);
        req_valid = 1'b0;
        repeat (200) @(negedge pclk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        chk("mid_rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_addr_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge pclk);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
